rv32_data_ram: RTL
==================

Name: rv32_data_ram

Overview:
Memory-side responder for the rv32 mem stage: a word-organised, byte-lane-addressable data RAM.
- Accepts load/store requests on a valid/ready handshake and inserts a configurable number of wait states.
- Returns one response pulse per request: load data (sign/zero-extended) plus a fault flag.
- Sits between the core's mem stage (initiator) and on-chip block RAM; the optional LED register replaces the core-side LED tap.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, 16 to 65536
WAIT_STATES, 1, extra cycles between accept and response; 0 to 15
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
req_valid_in  input  1  request present
req_ready_out  output  1  responder can accept (high only in IDLE)
req_write_in  input  1  1 = store, 0 = load
req_addr_in  input  32  byte address
req_width_in  input  2  00 byte, 01 half, 10 word, 11 reserved
req_zero_extend_in  input  1  load: 1 zero-extend, 0 sign-extend
req_wdata_in  input  32  store data, right-aligned (bits [7:0] for a byte)
resp_valid_out  output  1  one-cycle response pulse
resp_rdata_out  output  32  extended load data; 0 for stores and faults
resp_fault_out  output  1  request faulted; valid only with resp_valid_out

Behaviour:
- Reset (async, reset_n=0): state IDLE; req_ready_out=1, resp_valid_out=0, resp_rdata_out=0, resp_fault_out=0, wait counter=0. RAM contents are not cleared.
- Reset mid-operation: an accepted, uncommitted request is dropped; no write and no response.
- Accept: edge where req_valid_in && req_ready_out. Register all request fields.
- FSM states:
  - IDLE: on accept, go to WAIT (WAIT_STATES>0, counter loaded with WAIT_STATES-1) or to ACCESS.
  - WAIT: decrement counter; when it is 0, go to ACCESS.
  - ACCESS: commit the write or perform the RAM read, and compute the fault.
  - RESP: resp_valid_out=1 for exactly one cycle, then IDLE.
- Latency: resp_valid_out rises WAIT_STATES+2 cycles after the accept edge. Back-to-back requests: req_ready_out is low from accept until the cycle after RESP.
- No response backpressure; the initiator must take the response in the RESP cycle.
- Fault conditions (no RAM write, rdata=0, fault=1):
  - width=11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - (addr-BASE_ADDR) >= DEPTH_WORDS*4, unsigned; addresses below BASE_ADDR wrap and fault
- Store lanes:
  - byte: lane addr[1:0] gets wdata[7:0]
  - half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0]
  - word: all lanes
  - Unselected lanes are unchanged.
- Load: select the lane(s) the same way and shift to bit 0. Extend from bit 7 (byte) or bit 15 (half) unless zero_extend is set; word loads are passed through unchanged.
- Word index = (addr-BASE_ADDR)[log2(DEPTH_WORDS*4)-1:2].
- resp_rdata_out/resp_fault_out hold their values until the next RESP. Only resp_valid_out qualifies them.

Optional Feature:
RV32_DATA_RAM_LED_EN
- Defined:
  - Adds port leds output 8, reset value 8'h00.
  - Address 32'hFFFF_FFFC is an MMIO word, not a fault, for any width whose selected lanes include lane 0.
  - A store there sets leds <= byte lane 0 data.
  - A load there returns {24'b0,leds}, extended per width/zero_extend.
  - Other 0xFFFF_FFFx addresses follow the normal fault rules.
- Undefined: no leds port; that address faults as out of range.

Test Plan:
- Reset with req_valid_in=1 held -> req_ready_out=1, resp_valid_out=0, resp_rdata_out=0 immediately; no response after reset_n rises until a new accept.
- WAIT_STATES=1: store word 0xDEADBEEF at 0x10, then load word 0x10 -> resp_valid_out 3 cycles after each accept; load returns 0xDEADBEEF, fault=0.
- Store byte 0x80 to 0x11, then load byte 0x11 signed -> 0xFFFFFF80; load byte 0x11 zero-extended -> 0x00000080; load word 0x10 -> 0xDEAD80EF.
- Load half at 0x13, load word at 0x12, and width=11 at 0x10 -> each gives fault=1, rdata=0; word 0x10 still reads 0xDEAD80EF.
- DEPTH_WORDS=1024: store to 0x1000 -> fault=1, no write (word 0 unchanged); WAIT_STATES=0 gives the response 2 cycles after accept.
- Store word at 0x20, then pulse reset_n low in WAIT -> no response; load word 0x20 returns the old value. With RV32_DATA_RAM_LED_EN, a byte store of 0x5A to 0xFFFFFFFC sets leds=0x5A.

Source files
------------

// File: rtl/rv32_data_ram_if.sv
// rv32_data_ram_if: request/response bus between the rv32 mem stage and the
// data RAM responder.
//   master modport : the mem stage (drives requests, receives responses)
//   slave modport  : the RAM responder
// Request signals : req_valid_in, req_ready_out, req_write_in, req_addr_in,
//                   req_width_in, req_zero_extend_in, req_wdata_in
// Response signals: resp_valid_out, resp_rdata_out, resp_fault_out
interface rv32_data_ram_if;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_write_in;
  logic [31:0] req_addr_in;
  logic [1:0]  req_width_in;
  logic        req_zero_extend_in;
  logic [31:0] req_wdata_in;
  logic        resp_valid_out;
  logic [31:0] resp_rdata_out;
  logic        resp_fault_out;

  modport master (
    output req_valid_in, req_write_in, req_addr_in, req_width_in,
           req_zero_extend_in, req_wdata_in,
    input  req_ready_out, resp_valid_out, resp_rdata_out, resp_fault_out
  );

  modport slave (
    input  req_valid_in, req_write_in, req_addr_in, req_width_in,
           req_zero_extend_in, req_wdata_in,
    output req_ready_out, resp_valid_out, resp_rdata_out, resp_fault_out
  );
endinterface

// File: rtl/rv32_data_ram.sv
// rv32_data_ram: word-organised, byte-lane-addressable data RAM responding
// to load/store requests from the rv32 mem stage.
//   clk     : clock, all state on the rising edge
//   reset_n : asynchronous active-low reset (RAM contents are not cleared)
//   bus     : rv32_data_ram_if.slave request/response bus
//   leds    : 8-bit LED register output (only with RV32_DATA_RAM_LED_EN)
// Optional build macro RV32_DATA_RAM_LED_EN maps 32'hFFFF_FFFC to the LED
// register; when undefined that address faults as out of range.
// Response arrives WAIT_STATES+2 cycles after the accept edge.
module rv32_data_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  rv32_data_ram_if.slave    bus
`ifdef RV32_DATA_RAM_LED_EN
  ,
  output logic [7:0]        leds
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS * 4);
  localparam int unsigned IW = AW - 2;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [31:0] LED_ADDR = 32'hFFFF_FFFC;

  // S_LOAD is the block-RAM output stage: the read is registered at the end
  // of S_ACCESS and formatted for the response during S_LOAD.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_LOAD,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic        accept;

  logic        r_write;
  logic [31:0] r_addr;
  logic [1:0]  r_width;
  logic        r_zext;
  logic [31:0] r_wdata;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_q;

  logic [31:0] off;
  logic [IW-1:0] idx;
  logic        bad_width;
  logic        misalign;
  logic        out_of_range;
  logic        led_hit;
  logic        fault;
  logic [3:0]  be;
  logic [31:0] wrep;
  logic        do_write;
  logic [31:0] rd_word;
  logic [4:0]  lane_sh;
  logic [31:0] shifted;
  logic [31:0] ext;
  logic [31:0] load_data;

  logic [31:0] rdata_q;
  logic        fault_q;

  assign accept = bus.req_valid_in && (state == S_IDLE);

  assign bus.req_ready_out  = (state == S_IDLE);
  assign bus.resp_valid_out = (state == S_RESP);
  assign bus.resp_rdata_out = rdata_q;
  assign bus.resp_fault_out = fault_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (wait_cnt == '0) begin
          state_next = S_ACCESS;
        end
      end
      S_ACCESS: state_next = S_LOAD;
      S_LOAD:   state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Wait counter and captured request fields
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_width  <= '0;
      r_zext   <= 1'b0;
      r_wdata  <= '0;
    end else begin
      if (accept) begin
        wait_cnt <= WAIT_LOAD;
        r_write  <= bus.req_write_in;
        r_addr   <= bus.req_addr_in;
        r_width  <= bus.req_width_in;
        r_zext   <= bus.req_zero_extend_in;
        r_wdata  <= bus.req_wdata_in;
      end else if (state == S_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Address decode and fault detection. BASE_ADDR is aligned to the RAM
  // size, so the low offset bits equal the low address bits.
  always_comb begin
    off          = r_addr - BASE_ADDR;
    idx          = off[AW-1:2];
    bad_width    = (r_width == 2'b11);
    misalign     = ((r_width == 2'b01) && off[0]) ||
                   ((r_width == 2'b10) && (off[1:0] != 2'b00));
    out_of_range = |off[31:AW];
`ifdef RV32_DATA_RAM_LED_EN
    led_hit      = (r_addr == LED_ADDR) && !bad_width;
`else
    led_hit      = 1'b0;
`endif
    fault        = bad_width || misalign || (out_of_range && !led_hit);
  end

  // Store lane enables with the store data replicated onto every lane
  always_comb begin
    be   = 4'b0000;
    wrep = r_wdata;
    case (r_width)
      2'b00: begin
        be   = 4'b0001 << off[1:0];
        wrep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        be   = off[1] ? 4'b1100 : 4'b0011;
        wrep = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        be   = 4'b1111;
        wrep = r_wdata;
      end
      default: begin
        be   = 4'b0000;
        wrep = r_wdata;
      end
    endcase
  end

  assign do_write = (state == S_ACCESS) && r_write && !fault && !led_hit;

  // Block RAM: byte-lane write, registered read
  always_ff @(posedge clk) begin
    if (state == S_ACCESS) begin
      rd_q <= mem[idx];
    end
    if (do_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][i*8 +: 8] <= wrep[i*8 +: 8];
        end
      end
    end
  end

`ifdef RV32_DATA_RAM_LED_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      leds <= 8'h00;
    end else if (state == S_ACCESS && r_write && led_hit) begin
      leds <= r_wdata[7:0];
    end
  end
`endif

  // Load formatting: pick the lane(s), shift down to bit 0, then extend
  always_comb begin
`ifdef RV32_DATA_RAM_LED_EN
    rd_word = led_hit ? {24'h0, leds} : rd_q;
`else
    rd_word = rd_q;
`endif
    lane_sh = (r_width == 2'b01) ? {off[1], 4'b0000} : {off[1:0], 3'b000};
    shifted = rd_word >> lane_sh;
    case (r_width)
      2'b00:   ext = r_zext ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ext = r_zext ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
    load_data = (r_write || fault) ? '0 : ext;
  end

  // Response registers hold until the next response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else if (state == S_LOAD) begin
      rdata_q <= load_data;
      fault_q <= fault;
    end
  end

endmodule
